// File: rtl/core_id_stage.sv
// Instruction-decode pipeline stage: registers fetch PC/instruction, extends the immediate,
// selects operand sources and, when ID_HAZARD_EN is defined, interlocks load-use hazards.
//
// Instruction word layout (32 bits):
//   [31:26] opcode  [25:22] rega  [21:18] regb  [17] i (immediate operand)
//   [16] s (sign-extend)  [15:IMM_W] reserved  [IMM_W-1:0] immediate
module core_id_stage #(
  parameter int XLEN  = 32,
  parameter int IMM_W = 11,
  parameter int NFWD  = 2,
  parameter int SELW  = $clog2(NFWD + 3)
) (
  input  logic              clk,
  input  logic              rst,
  // fetch side
  input  logic              if_valid_i,
  output logic              if_ready_o,
  input  logic [XLEN-1:0]   if_pc_i,
  input  logic [31:0]       if_instr_i,
  input  logic              flush_i,
  // execute side
  input  logic              ex_ready_i,
  input  logic              ex_load_i,
  input  logic [3:0]        ex_waddr_i,
  input  logic [NFWD-1:0]   fwd_valid_i,
  input  logic [4*NFWD-1:0] fwd_addr_i,
  // decode outputs
  output logic              id_valid_o,
  output logic [XLEN-1:0]   id_pc_o,
  output logic [31:0]       id_instr_o,
  output logic [3:0]        rega_addr_o,
  output logic [3:0]        regb_addr_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [SELW-1:0]   opmux_a_o,
  output logic [SELW-1:0]   opmux_b_o,
  output logic              id_flushed_o
);

  typedef struct packed {
    logic [5:0]       opcode;
    logic [3:0]       rega;
    logic [3:0]       regb;
    logic             i;
    logic             s;
    logic [15-IMM_W:0] rsvd;
    logic [IMM_W-1:0] imm;
  } instr_t;

  localparam logic [5:0]      OPCODE_NOP = 6'h00;
  localparam logic [3:0]      RF_PC      = 4'hF;
  localparam logic [SELW-1:0] SEL_RF     = SELW'(0);
  localparam logic [SELW-1:0] SEL_PC     = SELW'(1);
  localparam logic [SELW-1:0] SEL_IMM    = SELW'(2);

  localparam instr_t NOP_INSTR   = instr_t'({OPCODE_NOP, 26'h0});
  localparam instr_t FLUSH_INSTR = instr_t'({OPCODE_NOP, {26{1'b1}}});

  // Extended immediate: zero when the instruction has no immediate operand.
  function automatic logic [XLEN-1:0] ext_imm(input logic i_bit, input logic s_bit,
                                              input logic [IMM_W-1:0] field);
    logic [XLEN-1:0] r;
    r = '0;
    if (i_bit) r = {{(XLEN-IMM_W){s_bit & field[IMM_W-1]}}, field};
    return r;
  endfunction

  // Register/PC/forwarding choice; scanning from the farthest source lets the nearest win.
  function automatic logic [SELW-1:0] src_sel(input logic [3:0]        addr,
                                              input logic [NFWD-1:0]   fv,
                                              input logic [4*NFWD-1:0] fa);
    logic [SELW-1:0] sel;
    sel = SEL_RF;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fv[k] && (fa[4*k +: 4] == addr)) sel = SELW'(k + 3);
    end
    if (addr == RF_PC) sel = SEL_PC;
    return sel;
  endfunction

  instr_t          if_instr;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] id_pc_q,     id_pc_d;
  instr_t          id_instr_q,  id_instr_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic            id_flushed_q, id_flushed_d;
  logic            hazard;
  logic            stall;

  assign if_instr = instr_t'(if_instr_i);

`ifdef ID_HAZARD_EN
  // Hazard looks at the internally held valid so the EX-facing bubble cannot feed back.
  assign hazard = out_valid_q & ex_load_i & (ex_waddr_i != RF_PC) &
                  ((ex_waddr_i == id_instr_q.rega) |
                   (~id_instr_q.i & (ex_waddr_i == id_instr_q.regb)));
`else
  logic unused_hazard_in;
  assign unused_hazard_in = ^{ex_load_i, ex_waddr_i};
  assign hazard           = 1'b0;
`endif

  assign stall      = (out_valid_q & ~ex_ready_i) | hazard;
  assign if_ready_o = ~stall | flush_i;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    out_valid_d  = out_valid_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    imm_d        = imm_q;
    id_flushed_d = id_flushed_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      id_instr_d   = FLUSH_INSTR;
      imm_d        = '0;
      id_flushed_d = 1'b1;
    end else if (!stall) begin
      out_valid_d  = if_valid_i;
      id_pc_d      = if_pc_i;
      id_instr_d   = if_valid_i ? if_instr : NOP_INSTR;
      imm_d        = ext_imm(if_instr.i, if_instr.s, if_instr.imm);
      id_flushed_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= NOP_INSTR;
      imm_q        <= '0;
      id_flushed_q <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      imm_q        <= imm_d;
      id_flushed_q <= id_flushed_d;
    end
  end

  assign id_valid_o   = out_valid_q & ~hazard;
  assign id_pc_o      = id_pc_q;
  assign id_instr_o   = id_instr_q;
  assign imm_o        = imm_q;
  assign id_flushed_o = id_flushed_q;
  assign rega_addr_o  = id_instr_q.rega;
  assign regb_addr_o  = id_instr_q.regb;

  // Operand A never selects the immediate; B does whenever the instruction carries one.
  assign opmux_a_o = src_sel(id_instr_q.rega, fwd_valid_i, fwd_addr_i);
  assign opmux_b_o = id_instr_q.i ? SEL_IMM
                                  : src_sel(id_instr_q.regb, fwd_valid_i, fwd_addr_i);

endmodule

// File: tb/tb_core_id_stage.sv
// Self-checking bench for core_id_stage: directed test-plan steps followed by random traffic,
// all compared against a behavioural model of the decode stage.
module tb_core_id_stage;
  localparam int XLEN  = 32;
  localparam int IMM_W = 11;
  localparam int NFWD  = 2;
  localparam int SELW  = $clog2(NFWD + 3);

  logic              clk, rst;
  logic              if_valid, if_ready, flush, ex_ready, ex_load;
  logic [XLEN-1:0]   if_pc, id_pc, imm;
  logic [31:0]       if_instr, id_instr;
  logic [3:0]        ex_waddr, rega_addr, regb_addr;
  logic [NFWD-1:0]   fwd_valid;
  logic [4*NFWD-1:0] fwd_addr;
  logic              id_valid, id_flushed;
  logic [SELW-1:0]   opmux_a, opmux_b;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  logic        m_valid, m_flushed;
  logic [31:0] m_pc, m_instr, m_imm;

  core_id_stage #(.XLEN(XLEN), .IMM_W(IMM_W), .NFWD(NFWD)) dut (
    .clk(clk), .rst(rst),
    .if_valid_i(if_valid), .if_ready_o(if_ready), .if_pc_i(if_pc), .if_instr_i(if_instr),
    .flush_i(flush), .ex_ready_i(ex_ready), .ex_load_i(ex_load), .ex_waddr_i(ex_waddr),
    .fwd_valid_i(fwd_valid), .fwd_addr_i(fwd_addr),
    .id_valid_o(id_valid), .id_pc_o(id_pc), .id_instr_o(id_instr),
    .rega_addr_o(rega_addr), .regb_addr_o(regb_addr), .imm_o(imm),
    .opmux_a_o(opmux_a), .opmux_b_o(opmux_b), .id_flushed_o(id_flushed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic i, input logic s,
                                     input logic [10:0] f);
    return {opc, ra, rb, i, s, 5'h0, f};
  endfunction

  // Immediate as an arithmetic value: signed field shifted into place and back.
  function automatic logic [31:0] m_ext(input logic [31:0] x);
    logic signed [31:0] t;
    if (!x[17]) return 32'h0;
    if (!x[16]) return {21'h0, x[10:0]};
    t = $signed({x[10:0], 21'h0});
    return 32'(t >>> 21);
  endfunction

  function automatic int m_sel(input logic [3:0] addr, input bit use_imm);
    if (use_imm) return 2;
    if (addr == 4'd15) return 1;
    for (int k = 0; k < NFWD; k++)
      if (fwd_valid[k] && fwd_addr[4*k +: 4] == addr) return 3 + k;
    return 0;
  endfunction

  function automatic bit m_hazard();
`ifdef ID_HAZARD_EN
    logic [3:0] ra, rb;
    ra = m_instr[25:22];
    rb = m_instr[21:18];
    return m_valid && ex_load && ex_waddr != 4'd15 &&
           (ex_waddr == ra || (!m_instr[17] && ex_waddr == rb));
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_valid = 0; m_flushed = 0; m_pc = 0; m_instr = 0; m_imm = 0;
  endtask

  task automatic compare_all(input string tag);
    bit hz, stall;
    hz    = m_hazard();
    stall = (m_valid && !ex_ready) || hz;
    check({tag, ".if_ready"},   if_ready,   !stall || flush);
    check({tag, ".id_valid"},   id_valid,   m_valid && !hz);
    check({tag, ".id_pc"},      id_pc,      m_pc);
    check({tag, ".id_instr"},   id_instr,   m_instr);
    check({tag, ".imm"},        imm,        m_imm);
    check({tag, ".id_flushed"}, id_flushed, m_flushed);
    check({tag, ".rega"},       rega_addr,  m_instr[25:22]);
    check({tag, ".regb"},       regb_addr,  m_instr[21:18]);
    check({tag, ".opmux_a"},    opmux_a,    m_sel(m_instr[25:22], 1'b0));
    check({tag, ".opmux_b"},    opmux_b,    m_sel(m_instr[21:18], m_instr[17]));
  endtask

  // Compare with the current inputs, then advance DUT and model by one clock.
  task automatic step(input string tag);
    bit          hz, stall;
    logic        n_valid, n_flushed;
    logic [31:0] n_pc, n_instr, n_imm;
    #1;
    compare_all(tag);
    hz = m_hazard();
    stall = (m_valid && !ex_ready) || hz;
    n_valid = m_valid; n_flushed = m_flushed; n_pc = m_pc; n_instr = m_instr; n_imm = m_imm;
    if (flush) begin
      n_valid = 0; n_flushed = 1; n_imm = 0; n_instr = 32'h03FF_FFFF;
    end else if (!stall) begin
      n_valid = if_valid; n_pc = if_pc; n_flushed = 0;
      n_instr = if_valid ? if_instr : 32'h0;
      n_imm = m_ext(if_instr);
    end
    @(posedge clk);
    m_valid = n_valid; m_flushed = n_flushed; m_pc = n_pc; m_instr = n_instr; m_imm = n_imm;
    #1;
  endtask

  initial begin
    if_valid = 0; if_pc = 0; if_instr = 0; flush = 0; ex_ready = 1; ex_load = 0;
    ex_waddr = 0; fwd_valid = 0; fwd_addr = 0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    m_reset();
    compare_all("reset");
    check("reset.instr_nop", id_instr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // immediate extension, aligned with the instruction
    if_valid = 1; if_pc = 32'd100; if_instr = mk(6'h01, 4'd3, 4'd4, 1, 1, 11'h7F0);
    step("imm_sext");
    check("imm_sext.value", imm, 32'hFFFF_FFF0);
    check("imm_sext.instr", id_instr, mk(6'h01, 4'd3, 4'd4, 1, 1, 11'h7F0));
    if_pc = 32'd104; if_instr = mk(6'h02, 4'd3, 4'd4, 1, 0, 11'h7F0);
    step("imm_zext");
    check("imm_zext.value", imm, 32'h0000_07F0);
    if_pc = 32'd108; if_instr = mk(6'h03, 4'd3, 4'd6, 0, 1, 11'h7F0);
    step("imm_none");
    check("imm_none.value", imm, 32'h0);
    check("imm_none.opb_not_imm", opmux_b != 3'd2, 1'b1);

    // forwarding priority on rega=3
    fwd_valid = 2'b11; fwd_addr = {4'd3, 4'd3};
    #1 check("fwd_both.opmux_a", opmux_a, 3'd3);
    fwd_valid = 2'b10;
    #1 check("fwd_far.opmux_a", opmux_a, 3'd4);
    if_pc = 32'd112; if_instr = mk(6'h04, 4'd15, 4'd5, 0, 0, 11'h0);
    fwd_valid = 2'b01; fwd_addr = {4'd0, 4'd15};
    step("fwd_pc");
    check("fwd_pc.opmux_a", opmux_a, 3'd1);

    // backpressure: three held cycles, then the next instruction loads once
    fwd_valid = 0; ex_ready = 0;
    if_pc = 32'd116; if_instr = mk(6'h05, 4'd1, 4'd2, 0, 0, 11'h0);
    for (int c = 0; c < 3; c++) begin
      step("bp_hold");
      check("bp_hold.pc_stable", id_pc, 32'd112);
    end
    check("bp_hold.if_ready", if_ready, 1'b0);
    ex_ready = 1;
    step("bp_release");
    check("bp_release.pc", id_pc, 32'd116);
    if_pc = 32'd120; if_instr = mk(6'h06, 4'd2, 4'd3, 0, 0, 11'h0);
    step("bp_next");
    check("bp_next.pc", id_pc, 32'd120);

    // flush while stalled
    ex_ready = 0; flush = 1; if_pc = 32'd124; if_instr = mk(6'h07, 4'd7, 4'd7, 0, 0, 11'h0);
    step("flush");
    check("flush.instr", id_instr, 32'h03FF_FFFF);
    check("flush.flushed", id_flushed, 1'b1);
    check("flush.valid", id_valid, 1'b0);
    check("flush.pc_held", id_pc, 32'd120);
    flush = 0; if_pc = 32'd128; if_instr = mk(6'h08, 4'd5, 4'd6, 0, 0, 11'h0);
    step("post_flush");
    check("post_flush.pc", id_pc, 32'd128);

    // load-use hazard on rega=5
    ex_ready = 1; ex_load = 1; ex_waddr = 4'd5;
    if_pc = 32'd132; if_instr = mk(6'h09, 4'd1, 4'd1, 0, 0, 11'h0);
    #1;
`ifdef ID_HAZARD_EN
    check("hazard.id_valid", id_valid, 1'b0);
    check("hazard.if_ready", if_ready, 1'b0);
`else
    check("hazard.id_valid", id_valid, 1'b1);
    check("hazard.if_ready", if_ready, 1'b1);
`endif
    step("hazard");
    ex_load = 0;
`ifdef ID_HAZARD_EN
    #1 check("hazard_done.pc", id_pc, 32'd128);
    check("hazard_done.valid", id_valid, 1'b1);
`else
    #1 check("hazard_done.pc", id_pc, 32'd132);
`endif
    step("hazard_after");

    // asynchronous reset while stalled with valid contents
    ex_ready = 0;
    step("pre_reset");
    #2 rst = 1'b0;
    #1;
    m_reset();
    compare_all("mid_reset");
    check("mid_reset.valid", id_valid, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    ex_ready = 1;
    step("after_reset");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      if_valid  = ($urandom_range(0, 3) != 0);
      if_pc     = $urandom;
      if_instr  = $urandom;
      flush     = ($urandom_range(0, 15) == 0);
      ex_ready  = ($urandom_range(0, 3) != 0);
      ex_load   = $urandom_range(0, 1);
      ex_waddr  = 4'($urandom_range(0, 15));
      fwd_valid = NFWD'($urandom);
      fwd_addr  = (4*NFWD)'($urandom);
      step("random");
    end
    #1 compare_all("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
